// File: rtl/ysyx_25020037_lsu_v2_if.sv
// Bundle of the LSU-facing signals: the EXU request, the WBU response and one AXI4 master port.
// The master modport is the LSU side. The slave modport is the EXU/WBU/interconnect side.
interface ysyx_25020037_lsu_v2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int TAG_W  = 5
);
  localparam int STRB_W = DATA_W / 8;

  // EXU request
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  // WBU response
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic [1:0]        resp_fault;

  // AXI4 write address / data / response
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  // AXI4 read address / data
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    input  req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    output req_ready,
    output resp_valid, resp_data, resp_tag, resp_fault,
    input  resp_ready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    output req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata, req_tag,
    input  req_ready,
    input  resp_valid, resp_data, resp_tag, resp_fault,
    output resp_ready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ysyx_25020037_lsu_v2.sv
// Load/store unit with a single outstanding access and one AXI4 master port.
// It sizes B/H/W/D accesses, sign- or zero-extends loads, and traps misaligned accesses before
// they reach the bus. It splits SLVERR and DECERR into separate faults and returns the request tag.
module ysyx_25020037_lsu_v2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic rst,
  ysyx_25020037_lsu_v2_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RESP} state_t;

  state_t             state;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [TAG_W-1:0]   tag_q;
  logic               aw_done;
  logic               w_done;
  logic               aw_fire;
  logic               w_fire;
  logic               unused_bus;

  // Misaligned when the address is not a multiple of the access size; D exists only on a 64-bit bus.
  function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (DATA_W != 64) || (|a[2:0]);
    endcase
  endfunction

  // Byte-enable mask for the access size, moved to the addressed lane.
  function automatic logic [STRB_W-1:0] strb_of(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [STRB_W-1:0] m;
    case (sz)
      2'd0:    m = STRB_W'(1);
      2'd1:    m = STRB_W'(3);
      2'd2:    m = STRB_W'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  // Extend the LSB-aligned load lane to the full data width.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw, input logic [1:0] sz,
                                                 input logic uns);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [31:0]       w;
    logic signed [DATA_W-1:0] r;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    r = raw;
    case (sz)
      2'd0:    if (uns) r = DATA_W'(raw[7:0]);  else r = DATA_W'(b);
      2'd1:    if (uns) r = DATA_W'(raw[15:0]); else r = DATA_W'(h);
      2'd2:    if (uns) r = DATA_W'(raw[31:0]); else r = DATA_W'(w);
      default: r = raw;
    endcase
    return r;
  endfunction

  // OKAY and EXOKAY are success; SLVERR maps to fault 2 and DECERR maps to fault 3.
  function automatic logic [1:0] fault_of(input logic [1:0] xresp);
    return xresp[1] ? {1'b1, xresp[0]} : 2'b00;
  endfunction

  // Only single-beat INCR bursts are issued, with a fixed ID.
  assign bus.awid    = ID_W'(AXI_ID);
  assign bus.arid    = ID_W'(AXI_ID);
  assign bus.awlen   = 8'd0;
  assign bus.arlen   = 8'd0;
  assign bus.awburst = 2'b01;
  assign bus.arburst = 2'b01;
  assign bus.wlast   = 1'b1;

  assign aw_fire = bus.awvalid & bus.awready;
  assign w_fire  = bus.wvalid & bus.wready;

  // IDs and rlast carry no information for single-beat, single-outstanding traffic.
  assign unused_bus = ^{bus.rid, bus.bid, bus.rlast};

  // Access FSM: every bus and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_tag   <= '0;
      bus.resp_fault <= 2'b00;
      bus.awvalid    <= 1'b0;
      bus.wvalid     <= 1'b0;
      bus.bready     <= 1'b0;
      bus.arvalid    <= 1'b0;
      bus.rready     <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
    end else begin
      case (state)
        // accept: latch the request and pre-form the bus fields
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            off_q         <= bus.req_addr[OFF_W-1:0];
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            tag_q         <= bus.req_tag;
            bus.araddr    <= bus.req_addr;
            bus.awaddr    <= bus.req_addr;
            bus.arsize    <= {1'b0, bus.req_size};
            bus.awsize    <= {1'b0, bus.req_size};
            bus.wdata     <= bus.req_wdata << {bus.req_addr[OFF_W-1:0], 3'b000};
            bus.wstrb     <= strb_of(bus.req_size, bus.req_addr[OFF_W-1:0]);
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            if (bus.req_op == 2'd0 || bus.req_op == 2'd3) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= DATA_W'(bus.req_addr);
              bus.resp_fault <= 2'b00;
              bus.resp_tag   <= bus.req_tag;
            end else if (misaligned(bus.req_addr, bus.req_size)) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_fault <= 2'b01;
              bus.resp_tag   <= bus.req_tag;
            end else if (bus.req_op == 2'd1) begin
              state       <= RD_A;
              bus.arvalid <= 1'b1;
            end else begin
              state       <= WR;
              bus.awvalid <= 1'b1;
              bus.wvalid  <= 1'b1;
            end
          end
        end
        // read address: hold arvalid until the slave takes it
        RD_A: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= RD_D;
          end
        end
        // read data: pick the addressed lane and extend it
        RD_D: begin
          if (bus.rvalid) begin
            bus.rready     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_tag   <= tag_q;
            bus.resp_fault <= fault_of(bus.rresp);
            bus.resp_data  <= bus.rresp[1] ? '0
                              : load_ext(bus.rdata >> {off_q, 3'b000}, size_q, uns_q);
            state          <= RESP;
          end
        end
        // write address/data: the two channels complete independently
        WR: begin
          if (aw_fire) begin
            bus.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            bus.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            bus.bready <= 1'b1;
            state      <= WR_B;
          end
        end
        // write response
        WR_B: begin
          if (bus.bvalid) begin
            bus.bready     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_tag   <= tag_q;
            bus.resp_fault <= fault_of(bus.bresp);
            bus.resp_data  <= '0;
            state          <= RESP;
          end
        end
        // response: hold everything stable until the WBU takes it
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_lsu_v2.sv
// Directed bench for ysyx_25020037_lsu_v2 with a scripted AXI slave, a vector table and
// hand-written sequences for response back-pressure and mid-transaction reset.
module tb_ysyx_25020037_lsu_v2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int TAG_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25020037_lsu_v2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TAG_W(TAG_W)) bus ();

  ysyx_25020037_lsu_v2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .TAG_W(TAG_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          aw_wait;
    int          w_wait;
    logic [31:0] exp_data;
    logic [1:0]  exp_fault;
    int          exp_lat;
    int          exp_ar;
    int          exp_aw;
    int          exp_b;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wfirst;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // slave configuration, written by the test process only
  int          aw_wait = 0;
  int          w_wait  = 0;
  logic        r_stall = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00;
  logic [1:0]  s_bresp = 2'b00;

  // slave state and handshake counters
  int          aw_cnt = 0;
  int          w_cnt  = 0;
  int          n_wfirst = 0;
  int          n_ar = 0;
  int          n_aw = 0;
  int          n_w  = 0;
  int          n_b  = 0;
  logic [31:0] cap_araddr;
  logic [2:0]  cap_arsize;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [7:0]  cap_awlen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] tag,
                              input logic [31:0] rdata, input logic [1:0] rresp, input logic [1:0] bresp,
                              input int aww, input int ww, input logic [31:0] ed, input logic [1:0] ef,
                              input int el, input int ear, input int eaw, input int eb,
                              input logic [31:0] ewd, input logic [3:0] ews, input logic ewf);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.tag = tag;
    v.rdata = rdata; v.rresp = rresp; v.bresp = bresp; v.aw_wait = aww; v.w_wait = ww;
    v.exp_data = ed; v.exp_fault = ef; v.exp_lat = el; v.exp_ar = ear; v.exp_aw = eaw;
    v.exp_b = eb; v.exp_wdata = ewd; v.exp_wstrb = ews; v.exp_wfirst = ewf;
    return v;
  endfunction

  // slave drivers, updated on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0;
      bus.wready  = 1'b0; bus.bvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0;
    end else begin
      bus.arready = bus.arvalid;
      bus.rvalid  = bus.rready && !r_stall;
      if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin bus.awready = 1'b0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      bus.bvalid = bus.bready;
      if (!bus.wvalid && bus.awvalid) n_wfirst++;
    end
    bus.rdata = s_rdata; bus.rresp = s_rresp; bus.rlast = 1'b1; bus.rid = '0;
    bus.bresp = s_bresp; bus.bid = '0;
  end

  // handshake monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.arvalid && bus.arready) begin
        n_ar <= n_ar + 1; cap_araddr <= bus.araddr; cap_arsize <= bus.arsize;
      end
      if (bus.awvalid && bus.awready) begin n_aw <= n_aw + 1; cap_awlen <= bus.awlen; end
      if (bus.wvalid && bus.wready) begin
        n_w <= n_w + 1; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb;
      end
      if (bus.bvalid && bus.bready) n_b <= n_b + 1;
    end
  end

  task automatic run_vec(input int idx, input vec_t v, input int hold);
    int a0, aw0, w0, b0, wf0, lat;
    logic [31:0] d0;
    logic [1:0]  f0;
    s_rdata = v.rdata; s_rresp = v.rresp; s_bresp = v.bresp;
    aw_wait = v.aw_wait; w_wait = v.w_wait;
    a0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b; wf0 = n_wfirst;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin @(negedge clk); lat++; end
    chk($sformatf("v%0d_req_ready_idle", idx), bus.req_ready, 1);
    if (!bus.req_ready) return;
    bus.resp_ready   = (hold == 0);
    bus.req_op       = v.op;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_tag      = v.tag;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    chk($sformatf("v%0d_req_ready_drop", idx), bus.req_ready, 0);
    while (!bus.resp_valid && lat < 50) begin @(negedge clk); lat++; end
    chk($sformatf("v%0d_resp_valid", idx), bus.resp_valid, 1);
    if (!bus.resp_valid) return;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_data", idx), bus.resp_data, v.exp_data);
    chk($sformatf("v%0d_fault", idx), bus.resp_fault, v.exp_fault);
    chk($sformatf("v%0d_tag", idx), bus.resp_tag, v.tag);
    d0 = bus.resp_data; f0 = bus.resp_fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_valid", idx, i), bus.resp_valid, 1);
      chk($sformatf("v%0d_hold%0d_data", idx, i), bus.resp_data, d0);
      chk($sformatf("v%0d_hold%0d_fault", idx, i), bus.resp_fault, f0);
      chk($sformatf("v%0d_hold%0d_tag", idx, i), bus.resp_tag, v.tag);
      chk($sformatf("v%0d_hold%0d_req_ready", idx, i), bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_resp_drop", idx), bus.resp_valid, 0);
    chk($sformatf("v%0d_req_ready_back", idx), bus.req_ready, 1);
    chk($sformatf("v%0d_ar_count", idx), n_ar - a0, v.exp_ar);
    chk($sformatf("v%0d_aw_count", idx), n_aw - aw0, v.exp_aw);
    chk($sformatf("v%0d_w_count", idx), n_w - w0, v.exp_aw);
    chk($sformatf("v%0d_b_count", idx), n_b - b0, v.exp_b);
    if (v.exp_ar > 0) begin
      chk($sformatf("v%0d_araddr", idx), cap_araddr, v.addr);
      chk($sformatf("v%0d_arsize", idx), cap_arsize, {1'b0, v.size});
    end
    if (v.exp_aw > 0) begin
      chk($sformatf("v%0d_wdata", idx), cap_wdata, v.exp_wdata);
      chk($sformatf("v%0d_wstrb", idx), cap_wstrb, v.exp_wstrb);
      chk($sformatf("v%0d_awlen", idx), cap_awlen, 0);
      chk($sformatf("v%0d_wfirst", idx), (n_wfirst - wf0) > 0, v.exp_wfirst);
    end
  endtask

  vec_t vecs[18];

  initial begin
    int n;
    //            op    sz    u     addr          wdata         tag    rdata         rr    br    aww ww  exp_data      f     lat ar aw b  exp_wdata     strb   wf
    vecs[0]  = mk(2'd1, 2'd0, 1'b0, 32'h8000_0003, 32'h0,       5'd1,  32'h8012_3456, 2'd0, 2'd0, 0, 0, 32'hFFFF_FF80, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[1]  = mk(2'd1, 2'd0, 1'b1, 32'h8000_0003, 32'h0,       5'd2,  32'h8012_3456, 2'd0, 2'd0, 0, 0, 32'h0000_0080, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[2]  = mk(2'd1, 2'd1, 1'b0, 32'h8000_0002, 32'h0,       5'd3,  32'h8001_1234, 2'd0, 2'd0, 0, 0, 32'hFFFF_8001, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[3]  = mk(2'd1, 2'd1, 1'b1, 32'h8000_0000, 32'h0,       5'd4,  32'h1234_F00D, 2'd0, 2'd0, 0, 0, 32'h0000_F00D, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[4]  = mk(2'd1, 2'd2, 1'b0, 32'h8000_0004, 32'h0,       5'd5,  32'hDEAD_BEEF, 2'd0, 2'd0, 0, 0, 32'hDEAD_BEEF, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[5]  = mk(2'd2, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 5'd6, 32'h0,       2'd0, 2'd0, 0, 0, 32'h0,        2'd0, 3, 0, 1, 1, 32'hBEEF_0000, 4'hC, 1'b0);
    vecs[6]  = mk(2'd2, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_565A, 5'd7, 32'h0,       2'd0, 2'd0, 0, 0, 32'h0,        2'd0, 3, 0, 1, 1, 32'h3456_5A00, 4'h2, 1'b0);
    vecs[7]  = mk(2'd2, 2'd2, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 5'd8, 32'h0,       2'd0, 2'd0, 0, 0, 32'h0,        2'd0, 3, 0, 1, 1, 32'hCAFE_F00D, 4'hF, 1'b0);
    vecs[8]  = mk(2'd1, 2'd2, 1'b0, 32'h8000_0001, 32'h0,       5'd9,  32'h1111_1111, 2'd0, 2'd0, 0, 0, 32'h0,        2'd1, 1, 0, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[9]  = mk(2'd2, 2'd1, 1'b0, 32'h8000_0003, 32'h0000_1234, 5'd10, 32'h0,      2'd0, 2'd0, 0, 0, 32'h0,        2'd1, 1, 0, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[10] = mk(2'd1, 2'd3, 1'b0, 32'h8000_0000, 32'h0,       5'd11, 32'h2222_2222, 2'd0, 2'd0, 0, 0, 32'h0,        2'd1, 1, 0, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[11] = mk(2'd0, 2'd2, 1'b0, 32'h1234_5678, 32'h0,       5'd12, 32'h0,        2'd0, 2'd0, 0, 0, 32'h1234_5678, 2'd0, 1, 0, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[12] = mk(2'd3, 2'd0, 1'b0, 32'h0000_ABCD, 32'h0,       5'd13, 32'h0,        2'd0, 2'd0, 0, 0, 32'h0000_ABCD, 2'd0, 1, 0, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[13] = mk(2'd2, 2'd2, 1'b0, 32'h8000_0010, 32'h1122_3344, 5'd14, 32'h0,      2'd0, 2'd3, 0, 0, 32'h0,        2'd3, 3, 0, 1, 1, 32'h1122_3344, 4'hF, 1'b0);
    vecs[14] = mk(2'd1, 2'd2, 1'b0, 32'h8000_0020, 32'h0,       5'd15, 32'h5566_7788, 2'd2, 2'd0, 0, 0, 32'h0,        2'd2, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[15] = mk(2'd1, 2'd0, 1'b1, 32'h8000_0021, 32'h0,       5'd16, 32'h5566_7788, 2'd1, 2'd0, 0, 0, 32'h0000_0077, 2'd0, 3, 1, 0, 0, 32'h0,        4'h0, 1'b0);
    vecs[16] = mk(2'd2, 2'd2, 1'b0, 32'h8000_0030, 32'hA5A5_A5A5, 5'd17, 32'h0,      2'd0, 2'd0, 3, 0, 32'h0,        2'd0, 6, 0, 1, 1, 32'hA5A5_A5A5, 4'hF, 1'b1);
    vecs[17] = mk(2'd2, 2'd1, 1'b0, 32'h8000_0032, 32'h0000_1357, 5'd18, 32'h0,      2'd0, 2'd0, 0, 2, 32'h0,        2'd0, 5, 0, 1, 1, 32'h1357_0000, 4'hC, 1'b0);

    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b1;

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_valids", {bus.resp_valid, bus.arvalid, bus.awvalid, bus.wvalid}, 0);
    chk("rst_readies", {bus.rready, bus.bready}, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_tag_fault", {bus.resp_tag, bus.resp_fault}, 0);
    chk("rst_len", {bus.awlen, bus.arlen}, 0);
    chk("rst_burst", {bus.awburst, bus.arburst}, 4'b0101);
    chk("rst_wlast", bus.wlast, 1);
    rst = 1'b0;
    @(negedge clk);

    n = 18;
    for (int i = 0; i < n; i++) run_vec(i, vecs[i], 0);

    // back-pressure from the WBU for five cycles on a load
    run_vec(100, vecs[4], 5);

    // reset while waiting for read data
    r_stall = 1'b1;
    bus.req_op = 2'd1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h8000_0040; bus.req_tag = 5'd21; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.rready; i++) @(negedge clk);
    chk("rstmid_in_rd_d", bus.rready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_arvalid", bus.arvalid, 0);
    chk("rstmid_rready", bus.rready, 0);
    chk("rstmid_req_ready", bus.req_ready, 1);
    chk("rstmid_resp_valid", bus.resp_valid, 0);
    rst = 1'b0;
    r_stall = 1'b0;
    @(negedge clk);
    run_vec(200, vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
